wb_bram_ctrl: RTL and testbench

Wishbone-to-BRAM access sequencer that sits between the Caravel user-area Wishbone slave port and the user BRAM macro. It decodes the user BRAM window, latches each request, drives the BRAM enable, byte-write and address lines, and returns a single-cycle `wbs_ack_o` after a fixed, parameterised number of wait states for both reads and writes. Out-of-window accesses are acknowledged immediately with zero data so the bus never hangs.

---
 rtl/wb_bram_pkg.sv | 8 +
 rtl/wb_bram_wait_cnt.sv | 22 ++
 rtl/wb_bram_ctrl.sv | 92 +++++++++
 tb/tb_wb_bram_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/wb_bram_pkg.sv
// wb_bram_pkg: shared state type and constants for the Wishbone-to-BRAM sequencer
package wb_bram_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    localparam logic [31:0] DEF_ADDR_BASE = 32'h3800_0000;
    localparam logic [31:0] DEF_ADDR_SIZE = 32'h0040_0000;
    localparam int unsigned DELAYS_MIN = 3;
    localparam int unsigned DELAYS_MAX = 255;
endpackage

// File: rtl/wb_bram_wait_cnt.sv
// wb_bram_wait_cnt: 8-bit wait-state counter with clear, enable and a last flag at DELAYS-2
//   clk, rst : clock, asynchronous active-high reset
//   clr, en  : clear has priority over count enable
//   cnt      : current count
//   last     : cnt has reached the final wait state
module wb_bram_wait_cnt #(
    parameter int unsigned DELAYS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] cnt,
    output logic       last
);
    localparam logic [7:0] LAST = 8'(DELAYS - 2);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 8'd1;
    assign last = cnt == LAST;
endmodule

// File: rtl/wb_bram_ctrl.sv
// wb_bram_ctrl: Wishbone slave to BRAM sequencer with fixed wait states and immediate ack on window misses
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   wbs_*              : Wishbone slave port (single-cycle ack, read data valid with ack)
//   bram_*             : BRAM macro port (byte address, byte write enables, registered read data)
//   busy               : sequencer not idle
module wb_bram_ctrl
    import wb_bram_pkg::*;
#(
    parameter int unsigned DELAYS    = 10,
    parameter logic [31:0] ADDR_BASE = DEF_ADDR_BASE,
    parameter logic [31:0] ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned AW        = 17
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic          bram_en,
    output logic [3:0]    bram_we,
    output logic [AW-1:0] bram_a,
    output logic [31:0]   bram_di,
    input  logic [31:0]   bram_do,
    output logic          busy
);
    if (DELAYS < DELAYS_MIN || DELAYS > DELAYS_MAX) begin : g_bad_delays
        $error("wb_bram_ctrl: DELAYS must be within 3..255");
    end
    // 33-bit end bound so a window touching the top of the address space does not wrap
    localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};
    state_t state, state_nx;
    logic [AW-1:0] a_r;
    logic [31:0] di_r, dat_r;
    logic [3:0] sel_r;
    logic we_r, req, hit, last;
    logic [7:0] cnt;
    logic [AW-1:0] off;
    assign req = wbs_stb_i & wbs_cyc_i;
    assign hit = wbs_adr_i >= ADDR_BASE && {1'b0, wbs_adr_i} < ADDR_END;
    assign off = wbs_adr_i[AW-1:0] - ADDR_BASE[AW-1:0];
    wb_bram_wait_cnt #(.DELAYS(DELAYS)) u_cnt (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .clr (state != WAIT),
        .en  (state == WAIT),
        .cnt (cnt),
        .last(last)
    );
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = req ? (hit ? WAIT : ACK) : IDLE;
            WAIT:    state_nx = !wbs_cyc_i ? IDLE : (last ? ACK : WAIT);
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            a_r   <= '0;
            di_r  <= '0;
            sel_r <= '0;
            we_r  <= 1'b0;
            dat_r <= '0;
        end else if (state == IDLE && req) begin
            dat_r <= '0;
            if (hit) begin
                a_r   <= off;
                di_r  <= wbs_dat_i;
                sel_r <= wbs_sel_i;
                we_r  <= wbs_we_i;
            end
        end else if (state == WAIT && last && !we_r) begin
            dat_r <= bram_do;
        end
    assign busy      = state != IDLE;
    assign wbs_ack_o = state == ACK;
    assign wbs_dat_o = wbs_ack_o ? dat_r : '0;
    assign bram_en   = state == WAIT;
    // cyc gating is the one input-to-output path: it lets an abort in the first wait cycle cancel the write
    assign bram_we   = (bram_en && cnt == 8'd0 && we_r && wbs_cyc_i) ? sel_r : 4'h0;
    assign bram_a    = a_r;
    assign bram_di   = di_r;
endmodule

// File: tb/tb_wb_bram_ctrl.sv
// tb_wb_bram_ctrl: scoreboard bench for wb_bram_ctrl at DELAYS=10 (index 0) and DELAYS=3 (index 1)
module tb_wb_bram_ctrl;
    typedef struct {
        int          k;
        int          cyc;
        logic [31:0] dat;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb [2];
    logic        cyc [2];
    logic        we [2];
    logic [3:0]  sel [2];
    logic [31:0] adr [2];
    logic [31:0] dat [2];
    logic        ack [2];
    logic [31:0] dat_o [2];
    logic        en [2];
    logic [3:0]  bwe [2];
    logic [16:0] ba [2];
    logic [31:0] di [2];
    logic        busy [2];
    int          cyc_n = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          en_cnt [2] = '{0, 0};
    logic [16:0] last_a [2];
    exp_t        q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] mem [256];
        logic [31:0] rd;
        wb_bram_ctrl #(.DELAYS(g == 0 ? 10 : 3)) dut (
            .wb_clk_i (clk),
            .wb_rst_i (rst),
            .wbs_stb_i(stb[g]),
            .wbs_cyc_i(cyc[g]),
            .wbs_we_i (we[g]),
            .wbs_sel_i(sel[g]),
            .wbs_adr_i(adr[g]),
            .wbs_dat_i(dat[g]),
            .wbs_ack_o(ack[g]),
            .wbs_dat_o(dat_o[g]),
            .bram_en  (en[g]),
            .bram_we  (bwe[g]),
            .bram_a   (ba[g]),
            .bram_di  (di[g]),
            .bram_do  (rd),
            .busy     (busy[g])
        );
        always @(posedge clk)
            if (en[g]) begin
                for (int b = 0; b < 4; b++)
                    if (bwe[g][b]) mem[ba[g][9:2]][8*b +: 8] <= di[g][8*b +: 8];
                rd <= mem[ba[g][9:2]];
            end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc_n);
        end
    endtask

    always @(negedge clk)
        for (int k = 0; k < 2; k++) begin
            if (en[k]) begin
                en_cnt[k] = en_cnt[k] + 1;
                last_a[k] = ba[k];
            end
            if (ack[k]) begin
                exp_t e;
                if (q.size() == 0) chk("unexpected_ack", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("ack_idx", k, e.k);
                    chk("ack_cycle", cyc_n, e.cyc);
                    chk("ack_data", dat_o[k], e.dat);
                end
            end
        end

    task automatic drive(input int k, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        stb[k] = 1'b1;
        cyc[k] = 1'b1;
        we[k]  = w;
        adr[k] = a;
        dat[k] = d;
        sel[k] = s;
    endtask

    task automatic req(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] e, input int lat);
        bit got = 0;
        @(negedge clk);
        drive(k, w, a, d, s);
        q.push_back('{k, cyc_n + lat, e});
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = ack[k];
        end
        if (!got) begin
            chk("ack_timeout", 0, 1);
            void'(q.pop_back());
        end
        stb[k] = 1'b0;
        cyc[k] = 1'b0;
    endtask

    initial begin
        int n, e0;
        for (int k = 0; k < 2; k++) begin
            stb[k] = 0; cyc[k] = 0; we[k] = 0; sel[k] = 0; adr[k] = 0; dat[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_ack", ack[k], 0);
            chk("rst_dat", dat_o[k], 0);
            chk("rst_en", en[k], 0);
            chk("rst_we", bwe[k], 0);
            chk("rst_a", ba[k], 0);
            chk("rst_di", di[k], 0);
            chk("rst_busy", busy[k], 0);
        end
        rst = 1'b0;

        req(0, 1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 0, 10);
        chk("write_bram_a", last_a[0], 17'h10);
        req(0, 0, 32'h3800_0010, 0, 4'hF, 32'hDEAD_BEEF, 10);
        chk("read_bram_a", last_a[0], 17'h10);

        req(0, 1, 32'h3800_0040, 32'h1122_3344, 4'hF, 0, 10);
        req(0, 1, 32'h3800_0040, 32'hAABB_CCDD, 4'b0101, 0, 10);
        req(0, 0, 32'h3800_0040, 0, 4'hF, 32'h11BB_33DD, 10);

        e0 = en_cnt[0];
        req(0, 0, 32'h3840_0000, 0, 4'hF, 0, 1);
        req(0, 0, 32'h37FF_FFFC, 0, 4'hF, 0, 1);
        req(0, 1, 32'h3840_0004, 32'hFFFF_FFFF, 4'hF, 0, 1);
        chk("miss_no_en", en_cnt[0] - e0, 0);

        @(negedge clk);
        drive(0, 0, 32'h3800_0000, 0, 4'hF);
        repeat (4) @(negedge clk);
        chk("abort_busy_before", busy[0], 1);
        stb[0] = 0;
        cyc[0] = 0;
        @(negedge clk);
        chk("abort_idle", busy[0], 0);
        repeat (12) @(negedge clk);
        req(0, 0, 32'h3800_0010, 0, 4'hF, 32'hDEAD_BEEF, 10);

        req(0, 1, 32'h3800_0020, 32'h5555_AAAA, 4'hF, 0, 10);
        @(negedge clk);
        drive(0, 1, 32'h3800_0020, 32'h1234_5678, 4'hF);
        @(negedge clk);
        chk("pre_rst_we", bwe[0], 4'hF);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", bwe[0], 0);
        chk("mid_rst_en", en[0], 0);
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_a", ba[0], 0);
        chk("mid_rst_di", di[0], 0);
        chk("mid_rst_ack", ack[0], 0);
        @(negedge clk);
        stb[0] = 0;
        cyc[0] = 0;
        rst = 1'b0;
        req(0, 0, 32'h3800_0020, 0, 4'hF, 32'h5555_AAAA, 10);

        req(1, 1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 0, 3);
        req(1, 0, 32'h3800_0010, 0, 4'hF, 32'hDEAD_BEEF, 3);
        req(1, 1, 32'h3800_0044, 32'hCAFE_F00D, 4'hF, 0, 3);
        @(negedge clk);
        drive(1, 0, 32'h3800_0044, 0, 4'hF);
        n = cyc_n;
        for (int i = 0; i < 3; i++) q.push_back('{1, n + 3 + 4 * i, 32'hCAFE_F00D});
        repeat (11) @(negedge clk);
        stb[1] = 0;
        cyc[1] = 0;
        repeat (6) @(negedge clk);
        chk("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
